// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/forward controls out.
// The pipeline side is master, the controller is slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNTW = 16
);
  logic [2:0]      RA1D, RA2D, RA1E, RA2E;
  logic [2:0]      WA3E, WA3M, WA3W;
  logic            RegWriteE, RegWriteM, RegWriteW;
  logic            MemtoRegE;
  logic            PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic            BranchTakenE;
  logic            MemReqM, MemReady;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, StallE, StallM;
  logic            FlushD, FlushE, FlushW;
  logic            MemErr;
  logic [CNTW-1:0] StallCount;

  modport master (
    output RA1D, RA2D, RA1E, RA2E,
    output WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW,
    output MemtoRegE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW,
    output BranchTakenE, MemReqM, MemReady,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  MemErr, StallCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E,
    input  WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW,
    input  MemtoRegE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW,
    input  BranchTakenE, MemReqM, MemReady,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output MemErr, StallCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding control for the 5-stage vector pipeline,
// with a memory-wait freeze FSM, timeout fault and stall counter.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input logic          clk,
  input logic          reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, FAULT} state_t;

  state_t          state;
  logic [WW-1:0]   wcnt;
  logic            merr;
  logic [CNTW-1:0] cnt;

  logic ldstall, pcpend, memstall;
  logic freeze, run;
  logic sf, sd, se, sm, fd, fe, fw;

  function automatic logic [1:0] fwd(
    input logic [2:0] ra,
    input logic       wm,
    input logic [2:0] am,
    input logic       ww,
    input logic [2:0] aw
  );
    if (wm && am == ra)      return 2'b10;
    else if (ww && aw == ra) return 2'b01;
    else                     return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd(hz.RA1E, hz.RegWriteM, hz.WA3M,
                            hz.RegWriteW, hz.WA3W);
  assign hz.ForwardBE = fwd(hz.RA2E, hz.RegWriteM, hz.WA3M,
                            hz.RegWriteW, hz.WA3W);

  assign ldstall  = hz.MemtoRegE && hz.RegWriteE &&
                    (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
  assign pcpend   = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
  assign memstall = hz.MemReqM & ~hz.MemReady;

  always_comb begin
    freeze = 1'b0;
    run    = 1'b0;
    sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
    fd = 1'b0; fe = 1'b0; fw = 1'b0;
    unique case (state)
      RUN:     if (memstall) freeze = 1'b1; else run = 1'b1;
      MEMWAIT: if (!hz.MemReady) freeze = 1'b1; else run = 1'b1;
      FAULT:   begin
        sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
      end
      default: run = 1'b1;
    endcase
    if (freeze) begin
      sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
      fw = 1'b1;
    end
    if (run) begin
      sf = ldstall | pcpend;
      sd = ldstall;
      fe = ldstall | hz.BranchTakenE;
      fd = pcpend | hz.PCSrcW | hz.BranchTakenE;
    end
    // Pipeline registers must stay quiet while reset is held.
    if (!reset) begin
      sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
      fd = 1'b0; fe = 1'b0; fw = 1'b0;
    end
  end

  assign hz.StallF     = sf;
  assign hz.StallD     = sd;
  assign hz.StallE     = se;
  assign hz.StallM     = sm;
  assign hz.FlushD     = fd;
  assign hz.FlushE     = fe;
  assign hz.FlushW     = fw;
  assign hz.MemErr     = merr;
  assign hz.StallCount = cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      wcnt  <= '0;
      merr  <= 1'b0;
      cnt   <= '0;
    end else begin
      if (sf && cnt != '1) cnt <= cnt + 1'b1;
      unique case (state)
        RUN: begin
          if (memstall) begin
            state <= MEMWAIT;
            wcnt  <= WW'(1);
          end
        end
        MEMWAIT: begin
          if (hz.MemReady) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (wcnt == WLAST) begin
            state <= FAULT;
            merr  <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an expectation queue
// checked at the falling edge.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNTW(CW)) hif ();

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNTW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned mcnt  = 0;

  logic [10:0] outv;
  assign outv = {hif.ForwardAE, hif.ForwardBE,
                 hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                 hif.FlushD, hif.FlushE, hif.FlushW};

  function automatic logic [10:0] mk(
    input logic [1:0] fa, input logic [1:0] fb,
    input logic sf, input logic sd, input logic se, input logic sm,
    input logic fd, input logic fe, input logic fw
  );
    return {fa, fb, sf, sd, se, sm, fd, fe, fw};
  endfunction

  task automatic push(input string tag, input int kind,
                      input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0:       obs = {21'b0, outv};
        1:       obs = {31'b0, hif.MemErr};
        default: obs = {16'b0, hif.StallCount};
      endcase
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s kind=%0d observed=%h expected=%h",
               e.tag, e.kind, obs, e.val);
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cyc(input string tag, input logic [10:0] v,
                     input logic me);
    #1;
    push(tag, 0, {21'b0, v});
    drain();
    @(posedge clk);
    if (!reset) mcnt = 0;
    else if (v[6]) mcnt++;
    @(negedge clk);
    push({tag, "_me"}, 1, {31'b0, me});
    push({tag, "_cnt"}, 2, mcnt);
    drain();
  endtask

  task automatic clr();
    hif.RA1D = '0; hif.RA2D = '0; hif.RA1E = '0; hif.RA2E = '0;
    hif.WA3E = '0; hif.WA3M = '0; hif.WA3W = '0;
    hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.MemtoRegE = 1'b0;
    hif.PCSrcD = 1'b0; hif.PCSrcE = 1'b0;
    hif.PCSrcM = 1'b0; hif.PCSrcW = 1'b0;
    hif.BranchTakenE = 1'b0;
    hif.MemReqM = 1'b0; hif.MemReady = 1'b0;
  endtask

  task automatic ldu();
    hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1;
    hif.WA3E = 3'd2; hif.RA2D = 3'd2;
  endtask

  logic [10:0] zero, frz, fault, lu;

  initial begin
    zero  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    frz   = mk(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1);
    fault = mk(2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 0);
    lu    = mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0);
    clr();
    reset = 1'b0;
    @(negedge clk);

    hif.RA1E = 3'd5; hif.WA3W = 3'd5; hif.RegWriteW = 1'b1;
    hif.MemReqM = 1'b1;
    cyc("rst_fwd", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    clr();
    reset = 1'b1;
    cyc("idle", zero, 1'b0);

    hif.RA1E = 3'd3; hif.WA3M = 3'd3; hif.RegWriteM = 1'b1;
    hif.WA3W = 3'd3; hif.RegWriteW = 1'b1;
    cyc("fwd_m", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    hif.RegWriteM = 1'b0; hif.RA2E = 3'd3;
    cyc("fwd_w", mk(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    hif.RA2E = 3'd6; hif.WA3M = 3'd6; hif.RegWriteM = 1'b1;
    cyc("fwd_mix", mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    clr();

    ldu();
    cyc("ldu", lu, 1'b0);
    clr();
    cyc("ldu_after", zero, 1'b0);

    ldu();
    hif.BranchTakenE = 1'b1;
    cyc("br_ldu", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0), 1'b0);
    clr();
    hif.PCSrcD = 1'b1;
    cyc("pcd", mk(2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0), 1'b0);
    clr();
    hif.PCSrcW = 1'b1;
    cyc("pcw", mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0), 1'b0);
    clr();

    hif.MemReqM = 1'b1;
    cyc("mw0", frz, 1'b0);
    cyc("mw1", frz, 1'b0);
    cyc("mw2", frz, 1'b0);
    hif.MemReady = 1'b1; hif.BranchTakenE = 1'b1;
    cyc("mw_rel", mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0), 1'b0);
    clr();
    cyc("mw_run", zero, 1'b0);

    hif.MemReqM = 1'b1;
    cyc("to0", frz, 1'b0);
    cyc("to1", frz, 1'b0);
    cyc("to2", frz, 1'b0);
    cyc("to3", frz, 1'b1);
    cyc("flt0", fault, 1'b1);
    hif.MemReady = 1'b1;
    cyc("flt_rdy", fault, 1'b1);
    clr();
    hif.PCSrcW = 1'b1;
    cyc("flt_pcw", fault, 1'b1);
    clr();

    reset = 1'b0;
    cyc("rst_flt", zero, 1'b0);
    reset = 1'b1;
    cyc("post_flt", zero, 1'b0);

    hif.MemReqM = 1'b1;
    cyc("mwr0", frz, 1'b0);
    cyc("mwr1", frz, 1'b0);
    reset = 1'b0;
    cyc("rst_mw", zero, 1'b0);
    reset = 1'b1;
    clr();
    cyc("post_mw", zero, 1'b0);
    ldu();
    cyc("post_ldu", lu, 1'b0);
    clr();
    cyc("end", zero, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage vector pipeline. It drives the stall enables and clears on every pipeline register, including the decode/execute register's `clr`. It also generates the operand forwarding selects for the 256-bit execute-stage operands. A small FSM freezes the pipeline while a vector memory access in the M stage waits on memory, with a timeout to a sticky fault state, and a saturating counter records stall cycles.

## Interface
- `TIMEOUT`, 64: maximum MEMWAIT cycles before entering FAULT (≥2).
- `CNTW`, 16: width of the stall-cycle counter.

- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `RA1D`, `RA2D`  in  3 each  source registers in D.
- `RA1E`, `RA2E`  in  3 each  source registers in E.
- `WA3E`, `WA3M`, `WA3W`  in  3 each  destination register in E/M/W.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each  register-write enables per stage.
- `MemtoRegE`  in  1  load in E.
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW`  in  1 each  PC-writing instruction in that stage.
- `BranchTakenE`  in  1  branch resolved taken in E.
- `MemReqM`  in  1  load or store in M.
- `MemReady`  in  1  memory completes the M access this cycle.
- `ForwardAE`, `ForwardBE`  out  2 each  operand select: 00 = RF, 01 = W result, 10 = M ALU result.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1 each  hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushW`  out  1 each  synchronous clear of the D, D/E and M/W registers.
- `MemErr`  out  1  sticky memory-timeout fault.
- `StallCount`  out  CNTW  saturating count of cycles with `StallF`=1.

## Operation
- **Forwarding** (combinational, always active, including during reset):
  - `ForwardAE`=10 if `RegWriteM` & `WA3M`==`RA1E`.
  - Else 01 if `RegWriteW` & `WA3W`==`RA1E`.
  - Else 00.
  - `ForwardBE` follows the same rules using `RA2E`.
  - M has priority over W.
- **Hazard terms:**
  - ldstall = `MemtoRegE` & `RegWriteE` & (`WA3E`==`RA1D` | `WA3E`==`RA2D`).
  - pcpend = `PCSrcD` | `PCSrcE` | `PCSrcM`.
  - memstall = `MemReqM` & !`MemReady`.
- **FSM states:** RUN, MEMWAIT, FAULT. Wait counter `wcnt` is 0..TIMEOUT-1.
- **RUN:**
  - memstall: all four stalls = 1, `FlushW`=1, `FlushD`=`FlushE`=0. `wcnt`←1, next state MEMWAIT.
  - Else compute each output independently:
    - `StallF` = ldstall | pcpend.
    - `StallD` = ldstall.
    - `FlushE` = ldstall | `BranchTakenE`.
    - `FlushD` = pcpend | `PCSrcW` | `BranchTakenE`.
    - `StallE` = `StallM` = `FlushW` = 0.
  - `StallD` takes precedence over `FlushD` at the D register.
- **MEMWAIT:**
  - While !`MemReady`: outputs identical to RUN-memstall and `wcnt` increments.
    - If `wcnt`==TIMEOUT-1, next state FAULT and `MemErr`←1.
  - On `MemReady`=1: evaluate the RUN equations this cycle, `wcnt`←0, next state RUN. The access completes.
- **FAULT:**
  - All four stalls = 1, all flushes = 0, `MemErr`=1.
  - Only reset leaves FAULT; `MemReady` is ignored.
- **StallCount:**
  - Increments at a clock edge when `StallF`=1.
  - Saturates at all-ones; never wraps.
- **Reset** (`reset`=0 at a rising edge):
  - State RUN, `wcnt`=0, `MemErr`=0, `StallCount`=0.
  - While `reset`=0, all stall and flush outputs are forced to 0.
  - Reset applied mid-MEMWAIT or in FAULT returns to RUN on the next edge.

## Timing
- Stall, flush and forward outputs are combinational from inputs and current state, valid in the same cycle. They take effect at the next rising edge of the pipeline registers.
- Load-use hazard: exactly one bubble. Next cycle the load is in M and ldstall deasserts.
- Memory wait: the pipeline freezes for N cycles when `MemReady` arrives N cycles after `MemReqM` first rises. It releases in the cycle `MemReady`=1.
- Fault entry: TIMEOUT cycles of stall, counted from the RUN cycle that detected memstall. `MemErr` is visible the cycle after.
- `StallCount` and `MemErr` are registered; they update one edge after the causing condition.

## Test plan
- **Forwarding.** Stimulus: `RA1E`=3, `WA3M`=3, `RegWriteM`=1, and also `WA3W`=3, `RegWriteW`=1. Required: `ForwardAE`=10. Then drop `RegWriteM`: required `ForwardAE`=01.
- **Load-use.** Stimulus: `MemtoRegE`=`RegWriteE`=1, `WA3E`=2, `RA2D`=2 for 1 cycle. Required: `StallF`=`StallD`=`FlushE`=1 that cycle only, and `StallCount` rises to 1.
- **Branch.** Stimulus: `BranchTakenE`=1 together with ldstall. Required: `FlushE`=1, `FlushD`=1, `StallD`=1, `StallF`=1.
- **Memory wait.** Stimulus: `MemReqM`=1, `MemReady`=0 for 3 cycles, then 1. Required: all stalls and `FlushW` asserted for 3 cycles, released in the 4th, state RUN afterwards, `StallCount`=3.
- **Timeout.** Stimulus: TIMEOUT=4, `MemReady` held 0. Required: `MemErr`=1 after the 4th stall cycle, stalls stay asserted, and a later `MemReady`=1 has no effect.
- **Reset.** Stimulus: `reset`=0 for one edge during MEMWAIT. Required: `MemErr`=0, `StallCount`=0, stalls and flushes 0, and normal RUN behaviour after `reset`=1.
